// File: rtl/sid_voice_amp_pkg.sv
// Shared SID definitions used by the voice amplitude modulator.
//   reg12_t     : 12-bit unsigned register value (waveform)
//   amp_t       : 20-bit signed amplitude product
//   phase_t     : phase strobe vector, indexed by PHI1_PHI2 / PHI2_PHI1
//   amp_state_t : multiplier FSM states
//   amp_term()  : sign-extended, shifted partial product for one multiplier step
package sid;

  typedef logic        [11:0] reg12_t;
  typedef logic signed [19:0] amp_t;

  localparam int unsigned PHASE_W   = 2;
  localparam int unsigned PHI1_PHI2 = 0;
  localparam int unsigned PHI2_PHI1 = 1;
  typedef logic [PHASE_W-1:0] phase_t;

  localparam int unsigned AMP_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } amp_state_t;

  // Partial product of a signed 12-bit operand for bit position s of the multiplier.
  function automatic amp_t amp_term(logic signed [11:0] w, logic [2:0] s);
    logic [19:0] ext;
    ext = {{8{w[11]}}, w};
    return amp_t'(ext << s);
  endfunction

endpackage

// File: rtl/sid_voice_amp_if.sv
// Voice amplitude modulator bus.
//   phase     : phase strobes (only PHI2_PHI1 starts a multiply)
//   wav       : unsigned waveform, 12'h800 is zero level
//   env       : envelope 0..255
//   out       : signed product, held between updates
//   out_valid : 1-clk pulse when out updates
// master drives the operands, slave is the modulator.
interface sid_voice_amp_if;
  import sid::*;

  phase_t      phase;
  reg12_t      wav;
  logic [7:0]  env;
  amp_t        out;
  logic        out_valid;

  modport master (
    output phase,
    output wav,
    output env,
    input  out,
    input  out_valid
  );

  modport slave (
    input  phase,
    input  wav,
    input  env,
    output out,
    output out_valid
  );

endinterface

// File: rtl/sid_voice_amp.sv
// Voice amplitude modulator: multiplies the centred 12-bit waveform by the 8-bit envelope
// with an 8-step sequential shift-add multiplier. A PHI2_PHI1 strobe captures operands;
// the product appears on out with a 1-clk out_valid pulse 9 clocks after the capture edge.
// A strobe arriving while busy aborts the running product and restarts with new operands.
//
// Ports:
//   clk   : system clock
//   res_n : asynchronous active-low reset
//   bus   : sid_voice_amp_if.slave (phase, wav, env in; out, out_valid out)
//
// Build option: define SID_AMP_DC_EN to subtract DC_OFFSET from the centred waveform and
// saturate to 12-bit signed before multiplying (6581 zero-level model). Latency is the
// same in both builds.
module sid_voice_amp
  import sid::*;
#(
  parameter logic signed [11:0] DC_OFFSET = 12'sd0
) (
  input logic              clk,
  input logic              res_n,
  sid_voice_amp_if.slave   bus
);

  logic strobe;
  assign strobe = bus.phase[PHI2_PHI1];

  // wav - 2048 is just the MSB inverted, read as signed.
  logic signed [11:0] wav_centered;
  assign wav_centered = {~bus.wav[11], bus.wav[10:0]};

  logic signed [11:0] wav_cap;

`ifdef SID_AMP_DC_EN
  logic signed [12:0] wav_off;

  always_comb begin
    wav_off = {wav_centered[11], wav_centered} - {DC_OFFSET[11], DC_OFFSET};
    // Top two bits differ only when the 13-bit difference left the 12-bit range.
    unique case (wav_off[12:11])
      2'b01:   wav_cap = 12'sh7FF;
      2'b10:   wav_cap = -12'sh800;
      default: wav_cap = wav_off[11:0];
    endcase
  end
`else
  logic unused_dc_offset;
  assign unused_dc_offset = ^DC_OFFSET;

  assign wav_cap = wav_centered;
`endif

  logic unused_phase;
  assign unused_phase = ^bus.phase;

  amp_state_t         state_q, state_d;
  logic [2:0]         step_q, step_d;
  amp_t               acc_q, acc_d;
  logic signed [11:0] wav_q, wav_d;
  logic [7:0]         env_q, env_d;
  amp_t               out_q, out_d;
  logic               valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    wav_d   = wav_q;
    env_d   = env_q;
    out_d   = out_q;
    valid_d = 1'b0;

    if (strobe) begin
      // Capture has priority over any state, which also implements the abort.
      wav_d   = wav_cap;
      env_d   = bus.env;
      acc_d   = '0;
      step_d  = '0;
      state_d = MUL;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        MUL: begin
          if (env_q[step_q]) begin
            acc_d = acc_q + amp_term(wav_q, step_q);
          end
          step_d = step_q + 3'd1;
          if (step_q == 3'(AMP_STEPS - 1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          out_d   = acc_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      wav_q   <= '0;
      env_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      wav_q   <= wav_d;
      env_q   <= env_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_sid_voice_amp.sv
// Scoreboard bench for sid_voice_amp: the driver pushes the expected product and the
// cycle it must appear on; a monitor pops and compares on every out_valid pulse.
// Build with SID_AMP_DC_EN defined to exercise the DC offset / saturation variant.
module tb_sid_voice_amp;
  import sid::*;

`ifdef SID_AMP_DC_EN
  localparam logic signed [11:0] TB_DC = 12'sd100;
`else
  localparam logic signed [11:0] TB_DC = 12'sd0;
`endif

  logic clk = 1'b0;
  logic res_n;
  always #5 clk = ~clk;

  sid_voice_amp_if bus ();

  sid_voice_amp #(
    .DC_OFFSET (TB_DC)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    amp_t val;
    int   at;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference product, independent of the shift-add structure.
  function automatic amp_t model(input reg12_t w, input logic [7:0] e);
    int ws;
    ws = int'(w) - 2048;
`ifdef SID_AMP_DC_EN
    ws = ws - 100;
    if (ws > 2047) ws = 2047;
    if (ws < -2048) ws = -2048;
`endif
    return amp_t'(ws * int'(e));
  endfunction

  always @(negedge clk) begin
    if (res_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_valid: got out_valid=1 out=0x%0h, expected no pulse (cycle %0d)",
                 bus.out, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("out", {12'b0, bus.out}, {12'b0, e.val});
        check("latency", cyc, e.at);
      end
    end
  end

  // Strobe at the next posedge; returns at the following negedge with the capture cycle.
  task automatic strobe(input reg12_t w, input logic [7:0] e, input bit push,
                        input amp_t expv, output int cap);
    @(negedge clk);
    bus.wav              = w;
    bus.env              = e;
    bus.phase            = '0;
    bus.phase[PHI2_PHI1] = 1'b1;
    @(posedge clk);
    #1;
    cap = cyc;
    if (push) sbq.push_back('{expv, cap + 9});
    @(negedge clk);
    bus.phase = '0;
    // Scramble inputs during MUL; the result must not depend on them.
    bus.wav   = 12'($urandom);
    bus.env   = 8'($urandom);
  endtask

  // Next strobe() captures exactly g clocks after the previous capture.
  task automatic gap(input int g);
    repeat (g - 2) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sbq.size() > 0; i++) @(negedge clk);
    check("drain_pending", sbq.size(), 0);
  endtask

  typedef struct {
    reg12_t     w;
    logic [7:0] e;
    amp_t       v;
  } vec_t;

`ifdef SID_AMP_DC_EN
  vec_t vecs[] = '{
    '{12'h000, 8'h01, -20'sd2048},
    '{12'h900, 8'h01, 20'sd156}
  };
`else
  vec_t vecs[] = '{
    '{12'hFFF, 8'hFF, 20'h7F701},
    '{12'h000, 8'hFF, 20'h80800},
    '{12'h800, 8'hA5, 20'h00000},
    '{12'h123, 8'h00, 20'h00000},
    '{12'h7FF, 8'h80, 20'hFFF80},
    '{12'hA00, 8'h03, 20'h00600}
  };
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int   cap;
    reg12_t w;
    logic [7:0] e;

    res_n     = 1'b0;
    bus.phase = '0;
    bus.wav   = '0;
    bus.env   = '0;
    repeat (3) @(negedge clk);
    check("reset_out", {12'b0, bus.out}, 32'h0);
    check("reset_valid", {31'b0, bus.out_valid}, 32'h0);
    res_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      strobe(vecs[i].w, vecs[i].e, 1'b1, vecs[i].v, cap);
      gap(12);
    end
    drain();

`ifndef SID_AMP_DC_EN
    // Abort: second strobe 4 clocks after the first; only the second result appears.
    strobe(12'hFFF, 8'h01, 1'b0, '0, cap);
    gap(4);
    strobe(12'h801, 8'h02, 1'b1, 20'sd2, cap);
    for (int i = 0; i < 8; i++) begin
      check("abort_hold", {12'b0, bus.out}, 32'h600);
      @(negedge clk);
    end
    drain();
    repeat (12) @(negedge clk);
`endif

    // Reset in the middle of a multiply: no output ever appears for it.
    strobe(12'hFFF, 8'hFF, 1'b0, '0, cap);
    repeat (3) @(negedge clk);
    #2 res_n = 1'b0;
    #1;
    check("midreset_out", {12'b0, bus.out}, 32'h0);
    check("midreset_valid", {31'b0, bus.out_valid}, 32'h0);
    repeat (2) @(negedge clk);
    check("midreset_hold", {12'b0, bus.out}, 32'h0);
    res_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_reset_out", {12'b0, bus.out}, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      w = 12'($urandom);
      e = 8'($urandom);
      strobe(w, e, 1'b1, model(w, e), cap);
      gap(int'($urandom_range(40, 10)));
    end
    drain();
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
